patblt_udiv_20ns_10ns_seq: RTL and testbench
============================================

# patblt_udiv_20ns_10ns_seq

Sequential unsigned divider, the inverse of the pattern engine's 10×10→20 multiplier. It converts a linear pixel offset back into row/column form: quotient = offset / width (row), remainder = offset % width (column). It computes a 20-bit / 10-bit restoring division, one quotient bit per clock, and sits inside the patblt datapath under an ap_start/ap_done block-level handshake.

## Interface
Parameters:
- DIVIDEND_WIDTH, 20, dividend and quotient width
- DIVISOR_WIDTH, 10, divisor and remainder width; must satisfy DIVISOR_WIDTH ≤ DIVIDEND_WIDTH

Ports (single clock `ap_clk`; reset `ap_rst` is synchronous, active-high):
- ap_clk  in  1  clock; all state updates on the rising edge
- ap_rst  in  1  synchronous active-high reset
- ap_start  in  1  request; sampled only in IDLE
- ap_ready  out  1  high in the cycle operands are captured
- ap_idle  out  1  high in IDLE
- ap_done  out  1  one-cycle pulse when results become valid
- dividend  in  DIVIDEND_WIDTH  unsigned numerator
- divisor  in  DIVISOR_WIDTH  unsigned denominator
- quotient  out  DIVIDEND_WIDTH  registered result
- remainder  out  DIVISOR_WIDTH  registered result
- dbz  out  1  divide-by-zero flag for the last result

## Operation
- States: IDLE, BUSY, DONE.
- IDLE → BUSY when ap_start=1.
  - ap_ready=1 combinationally in that cycle.
  - dividend and divisor are latched.
  - Bit counter is loaded with DIVIDEND_WIDTH-1.
  - Partial remainder (DIVISOR_WIDTH+1 bits) is cleared.
- BUSY performs one restoring step per cycle, MSB first:
  - r' = {r, next dividend bit}.
  - If r' ≥ divisor: r ← r' − divisor and the quotient bit is 1.
  - Otherwise: r ← r' and the quotient bit is 0.
  - The counter decrements each step; after the step at count 0, go to DONE.
- DONE lasts exactly 1 cycle.
  - ap_done=1.
  - quotient, remainder and dbz are updated from working registers on entry to DONE.
  - The next state is always IDLE.
- Divisor = 0, detected at capture:
  - The iteration runs normally and keeps the fixed latency.
  - Results are forced: quotient = all ones, remainder = dividend[DIVISOR_WIDTH-1:0], dbz=1.
- Otherwise dbz=0.
- Outputs hold their last values until the next DONE. Inputs may change freely after the capture cycle.
- ap_start is ignored in BUSY and DONE.
- Reset values:
  - state=IDLE
  - ap_idle=1
  - ap_ready=0, ap_done=0
  - quotient=0, remainder=0, dbz=0
- Reset mid-operation: the state machine returns to IDLE on the next edge, the computation is abandoned and no ap_done is produced.

## Timing
- Capture edge T (ap_start=1 in IDLE): BUSY during cycles T+1 … T+DIVIDEND_WIDTH.
- ap_done is high in cycle T+DIVIDEND_WIDTH+1 (T+21 at default widths), and results are valid in that same cycle.
- ap_idle is high again at T+DIVIDEND_WIDTH+2.
  - Earliest next capture is in that cycle.
  - Throughput is one division per DIVIDEND_WIDTH+2 cycles.
- ap_start held continuously high yields back-to-back operations at exactly that period.
- Latency is data-independent, including the divide-by-zero case.

## Structure
- Package `patblt_div_pkg` holds:
  - DIVIDEND_WIDTH/DIVISOR_WIDTH defaults
  - the state enum (IDLE, BUSY, DONE)
  - the counter width constant, $clog2(DIVIDEND_WIDTH)
- Sub-module `patblt_udiv_step` is purely combinational:
  - inputs: partial remainder, next dividend bit, divisor
  - outputs: new partial remainder, quotient bit
  - it is unit-testable in isolation.
- The top level contains the FSM, the counter, the working shift registers and the output registers.

## Test plan
- 1000 / 7 started at T → ap_done at T+21 with quotient=142, remainder=6, dbz=0; ap_ready high only at T.
- 1048575 / 1023 → quotient=1025, remainder=0.
- 5 / 9 → quotient=0, remainder=5.
- 12345 / 0 → quotient=0xFFFFF, remainder=57, dbz=1, ap_done at T+21.
- ap_rst asserted at T+10 of a running op → IDLE next cycle, no ap_done, outputs zero. A new 100/10 op then returns 10 r0.
- ap_start held high with changing operands → ap_done every 22 cycles; each result matches the operands captured in its own ap_ready cycle.

Source files
------------

// File: rtl/patblt_div_pkg.sv
// Shared widths, state encoding and counter sizing for the patblt sequential divider.
package patblt_div_pkg;

  localparam int unsigned DEF_DIVIDEND_WIDTH = 20;
  localparam int unsigned DEF_DIVISOR_WIDTH  = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter must hold DIVIDEND_WIDTH-1; never let it collapse to zero width.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int unsigned CNT_W = cnt_width(DEF_DIVIDEND_WIDTH);

endpackage

// File: rtl/patblt_udiv_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module patblt_udiv_step
  import patblt_div_pkg::*;
#(
  parameter int unsigned DIVISOR_WIDTH = DEF_DIVISOR_WIDTH
) (
  input  logic [DIVISOR_WIDTH:0]   i_rem,
  input  logic                     i_bit,
  input  logic [DIVISOR_WIDTH-1:0] i_divisor,
  output logic [DIVISOR_WIDTH:0]   o_rem,
  output logic                     o_qbit
);

  localparam int unsigned SW = DIVISOR_WIDTH + 2;
  localparam int unsigned RW = DIVISOR_WIDTH + 1;

  logic [SW-1:0] w_shift;
  logic [SW-1:0] w_diff;

  // One spare bit above the partial remainder so the compare never wraps.
  assign w_shift = {i_rem, i_bit};
  assign w_diff  = w_shift - SW'(i_divisor);
  assign o_qbit  = (w_shift >= SW'(i_divisor));
  assign o_rem   = o_qbit ? RW'(w_diff) : RW'(w_shift);

endmodule

// File: rtl/patblt_udiv_20ns_10ns_seq.sv
// Sequential 20/10 unsigned divider (offset -> row/column), one quotient bit per clock,
// wrapped in an ap_start/ap_ready/ap_idle/ap_done block handshake.
module patblt_udiv_20ns_10ns_seq
  import patblt_div_pkg::*;
#(
  parameter int unsigned DIVIDEND_WIDTH = DEF_DIVIDEND_WIDTH,
  parameter int unsigned DIVISOR_WIDTH  = DEF_DIVISOR_WIDTH
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic                      ap_start,
  output logic                      ap_ready,
  output logic                      ap_idle,
  output logic                      ap_done,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      dbz
);

  localparam int unsigned CW = cnt_width(DIVIDEND_WIDTH);

  state_t                    r_state;
  logic [CW-1:0]             r_cnt;
  logic [DIVIDEND_WIDTH-1:0] r_work;
  logic [DIVISOR_WIDTH-1:0]  r_divisor;
  logic [DIVISOR_WIDTH-1:0]  r_dvd_lo;
  logic [DIVISOR_WIDTH:0]    r_rem;
  logic                      r_zero;

  logic                      w_start;
  logic                      w_qbit;
  logic [DIVISOR_WIDTH:0]    w_rem_nxt;
  logic [DIVIDEND_WIDTH-1:0] w_work_nxt;

  assign w_start  = (r_state == IDLE) && ap_start;
  assign ap_ready = w_start;
  assign ap_idle  = (r_state == IDLE);
  assign ap_done  = (r_state == DONE);

  // r_work drains dividend bits from the top while quotient bits fill in from the bottom.
  assign w_work_nxt = {r_work[DIVIDEND_WIDTH-2:0], w_qbit};

  patblt_udiv_step #(
    .DIVISOR_WIDTH (DIVISOR_WIDTH)
  ) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_work[DIVIDEND_WIDTH-1]),
    .i_divisor (r_divisor),
    .o_rem     (w_rem_nxt),
    .o_qbit    (w_qbit)
  );

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_work    <= '0;
      r_divisor <= '0;
      r_dvd_lo  <= '0;
      r_rem     <= '0;
      r_zero    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_work    <= dividend;
            r_divisor <= divisor;
            r_dvd_lo  <= dividend[DIVISOR_WIDTH-1:0];
            r_zero    <= (divisor == '0);
            r_cnt     <= CW'(DIVIDEND_WIDTH - 1);
            r_rem     <= '0;
            r_state   <= BUSY;
          end
        end
        BUSY: begin
          r_rem  <= w_rem_nxt;
          r_work <= w_work_nxt;
          r_cnt  <= r_cnt - CW'(1);
          if (r_cnt == '0) begin
            // Divide-by-zero still runs the full iteration; only the published result is forced.
            quotient  <= r_zero ? '1 : w_work_nxt;
            remainder <= r_zero ? r_dvd_lo : DIVISOR_WIDTH'(w_rem_nxt);
            dbz       <= r_zero;
            r_state   <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_patblt_udiv_20ns_10ns_seq.sv
// Bench for the patblt sequential divider: directed cases, divide-by-zero, mid-op reset,
// back-to-back streaming and random operands against an arithmetic reference.
module tb_patblt_udiv_20ns_10ns_seq;

  localparam int unsigned DW  = 20;
  localparam int unsigned VW  = 10;
  localparam int          LAT = 21;
  localparam int          PER = 22;

  typedef struct packed {
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          z;
  } exp_t;

  logic          ap_clk = 1'b0;
  logic          ap_rst;
  logic          ap_start;
  logic          ap_ready;
  logic          ap_idle;
  logic          ap_done;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          dbz;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 ap_clk = ~ap_clk;

  patblt_udiv_20ns_10ns_seq dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .ap_start  (ap_start),
    .ap_ready  (ap_ready),
    .ap_idle   (ap_idle),
    .ap_done   (ap_done),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain integer division, with the fixed divide-by-zero result.
  function automatic exp_t model(input logic [DW-1:0] a, input logic [VW-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q = '1;
      e.r = a[VW-1:0];
      e.z = 1'b1;
    end else begin
      e.q = a / DW'(b);
      e.r = VW'(a % DW'(b));
      e.z = 1'b0;
    end
    return e;
  endfunction

  // Runs one operation; reports results, cycles from capture to ap_done, and handshake observations.
  task automatic do_op(input logic [DW-1:0] a, input logic [VW-1:0] b, output exp_t got,
                       output int lat, output logic rdy_cap, output int rdy_extra,
                       output logic idle_after);
    @(negedge ap_clk);
    dividend = a;
    divisor  = b;
    ap_start = 1'b1;
    #1 rdy_cap = ap_ready;
    @(posedge ap_clk);
    #1;
    ap_start = 1'b0;
    dividend = DW'($urandom);
    divisor  = VW'($urandom);
    lat       = 1;
    rdy_extra = 0;
    while (lat < 40) begin
      @(negedge ap_clk);
      if (ap_done) break;
      if (ap_ready) rdy_extra++;
      @(posedge ap_clk);
      lat++;
    end
    got.q = quotient;
    got.r = remainder;
    got.z = dbz;
    @(negedge ap_clk);
    idle_after = ap_idle && !ap_done;
  endtask

  task automatic test_reset();
    ap_rst   = 1'b1;
    ap_start = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    @(negedge ap_clk);
    n_checks++;
    if (ap_idle !== 1'b1 || ap_ready !== 1'b0 || ap_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: idle=%b ready=%b done=%b expected 1 0 0", ap_idle, ap_ready, ap_done);
    end
    n_checks++;
    if (quotient !== '0 || remainder !== '0 || dbz !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: q=%0d r=%0d dbz=%b expected 0 0 0", quotient, remainder, dbz);
    end
  endtask

  task automatic test_dbz();
    exp_t got;
    int lat, extra;
    logic rdy, idle;
    do_op(20'd12345, 10'd0, got, lat, rdy, extra, idle);
    n_checks++;
    if (got.q !== 20'hFFFFF || got.r !== 10'd57 || got.z !== 1'b1) begin
      n_fail++;
      $display("FAIL dbz_result: q=%h r=%0d dbz=%b expected fffff 57 1", got.q, got.r, got.z);
    end
    n_checks++;
    if (lat !== LAT) begin
      n_fail++;
      $display("FAIL dbz_latency: got %0d expected %0d", lat, LAT);
    end
  endtask

  task automatic test_directed();
    logic [DW-1:0] ta [3] = '{20'd1000, 20'd1048575, 20'd5};
    logic [VW-1:0] tb [3] = '{10'd7, 10'd1023, 10'd9};
    logic [DW-1:0] tq [3] = '{20'd142, 20'd1025, 20'd0};
    logic [VW-1:0] tr [3] = '{10'd6, 10'd0, 10'd5};
    exp_t got;
    int lat, extra;
    logic rdy, idle;
    for (int i = 0; i < 3; i++) begin
      do_op(ta[i], tb[i], got, lat, rdy, extra, idle);
      n_checks++;
      if (got.q !== tq[i] || got.r !== tr[i] || got.z !== 1'b0) begin
        n_fail++;
        $display("FAIL directed_%0d: q=%0d r=%0d dbz=%b expected %0d %0d 0", i, got.q, got.r, got.z, tq[i], tr[i]);
      end
      n_checks++;
      if (lat !== LAT) begin
        n_fail++;
        $display("FAIL directed_latency_%0d: got %0d expected %0d", i, lat, LAT);
      end
      n_checks++;
      if (rdy !== 1'b1 || extra !== 0) begin
        n_fail++;
        $display("FAIL directed_ready_%0d: ready_at_capture=%b extra_ready=%0d expected 1 0", i, rdy, extra);
      end
      n_checks++;
      if (idle !== 1'b1) begin
        n_fail++;
        $display("FAIL directed_idle_after_%0d: got %b expected 1", i, idle);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t got;
    int lat, extra, dones;
    logic rdy, idle;
    @(negedge ap_clk);
    dividend = 20'd12345;
    divisor  = 10'd7;
    ap_start = 1'b1;
    @(posedge ap_clk);
    #1 ap_start = 1'b0;
    repeat (9) @(posedge ap_clk);
    #1 ap_rst = 1'b1;
    @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    @(negedge ap_clk);
    n_checks++;
    if (ap_idle !== 1'b1 || quotient !== '0 || remainder !== '0 || dbz !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_state: idle=%b q=%0d r=%0d dbz=%b expected 1 0 0 0", ap_idle, quotient, remainder, dbz);
    end
    dones = 0;
    repeat (30) begin
      @(negedge ap_clk);
      if (ap_done) dones++;
    end
    n_checks++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL midreset_no_done: got %0d done pulses expected 0", dones);
    end
    do_op(20'd100, 10'd10, got, lat, rdy, extra, idle);
    n_checks++;
    if (got.q !== 20'd10 || got.r !== 10'd0 || got.z !== 1'b0 || lat !== LAT) begin
      n_fail++;
      $display("FAIL midreset_recover: q=%0d r=%0d dbz=%b lat=%0d expected 10 0 0 %0d", got.q, got.r, got.z, lat, LAT);
    end
  endtask

  task automatic test_back_to_back();
    exp_t q_exp[$];
    exp_t e, got;
    int last_rdy, last_done, n_done, n_rdy, bad_per, bad_res, orphan;
    last_rdy  = -1;
    last_done = -1;
    n_done = 0; n_rdy = 0; bad_per = 0; bad_res = 0; orphan = 0;
    @(posedge ap_clk);
    #1;
    ap_start = 1'b1;
    dividend = DW'($urandom);
    divisor  = VW'($urandom);
    for (int cyc = 0; cyc < 140; cyc++) begin
      @(negedge ap_clk);
      if (ap_ready) begin
        q_exp.push_back(model(dividend, divisor));
        if (last_rdy >= 0 && cyc - last_rdy != PER) bad_per++;
        last_rdy = cyc;
        n_rdy++;
      end
      if (ap_done) begin
        if (last_done >= 0 && cyc - last_done != PER) bad_per++;
        last_done = cyc;
        n_done++;
        got.q = quotient;
        got.r = remainder;
        got.z = dbz;
        if (q_exp.size() == 0) orphan++;
        else begin
          e = q_exp.pop_front();
          if (got !== e) begin
            bad_res++;
            $display("FAIL b2b_result: q=%0d r=%0d dbz=%b expected %0d %0d %b", got.q, got.r, got.z, e.q, e.r, e.z);
          end
        end
      end
      @(posedge ap_clk);
      #1;
      ap_start = (cyc + 1 < 120);
      dividend = DW'($urandom);
      divisor  = (($urandom % 8) == 0) ? '0 : VW'($urandom);
    end
    n_checks++;
    if (bad_res !== 0) n_fail++;
    n_checks++;
    if (bad_per !== 0) begin
      n_fail++;
      $display("FAIL b2b_period: got %0d off-period events expected 0", bad_per);
    end
    n_checks++;
    if (n_done !== 6 || n_rdy !== 6 || orphan !== 0 || q_exp.size() !== 0) begin
      n_fail++;
      $display("FAIL b2b_count: done=%0d ready=%0d orphan=%0d pending=%0d expected 6 6 0 0",
               n_done, n_rdy, orphan, q_exp.size());
    end
  endtask

  task automatic test_random();
    exp_t got, e;
    int lat, extra;
    logic rdy, idle;
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    for (int i = 0; i < 30; i++) begin
      a = DW'($urandom);
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = VW'($urandom_range(1, 15));
        default: b = VW'($urandom);
      endcase
      e = model(a, b);
      do_op(a, b, got, lat, rdy, extra, idle);
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL random_%0d (%0d/%0d): q=%0d r=%0d dbz=%b expected %0d %0d %b",
                 i, a, b, got.q, got.r, got.z, e.q, e.r, e.z);
      end
      n_checks++;
      if (lat !== LAT || rdy !== 1'b1 || extra !== 0 || idle !== 1'b1) begin
        n_fail++;
        $display("FAIL random_timing_%0d: lat=%0d ready=%b extra=%0d idle=%b expected %0d 1 0 1",
                 i, lat, rdy, extra, idle, LAT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_dbz();
    test_directed();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
